// File: rtl/parity_packer_pkg.sv
// Shared definitions for the byte-to-word parity packer: byte width,
// packer FSM states and the byte-count width helper.
package parity_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    // Count must represent 0..num_bytes inclusive.
    function automatic int count_width(input int num_bytes);
        return $clog2(num_bytes + 1);
    endfunction

endpackage

// File: rtl/parity_packer_word_parity.sv
// Purpose: XOR reduction of a packed word, optionally inverted for odd parity.
// Latency: purely combinational. Backpressure: none, no handshake.
// Zero-padded lanes contribute nothing, so partial words need no masking.
module word_parity
    import parity_pkg::*;
#(
    parameter int NUM_BYTES  = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic [NUM_BYTES*BYTE_W-1:0] word,
    output logic                        parity
);

    assign parity = (^word) ^ ODD_PARITY;

endmodule

// File: rtl/parity_packer.sv
// Purpose: packs a valid/ready byte stream little-endian into NUM_BYTES words with parity and count.
// Latency: word-completing byte accepted at edge N shows out_valid after edge N when the output is free.
// Backpressure: a completed word waits in the accumulator (HOLD, in_ready=0) until the output frees.
// Optional statistics counters are built only when PARITY_PACKER_STATS_EN is defined.
module parity_packer
    import parity_pkg::*;
#(
    parameter int NUM_BYTES  = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [BYTE_W-1:0]                       in_data,
    input  logic                                    in_valid,
    input  logic                                    in_last,
    output logic                                    in_ready,
    output logic [NUM_BYTES*BYTE_W-1:0]             out_data,
    output logic [count_width(NUM_BYTES)-1:0]       out_count,
    output logic                                    out_parity,
    output logic                                    out_valid,
    input  logic                                    out_ready
`ifdef PARITY_PACKER_STATS_EN
    ,
    output logic [15:0]                             stat_words,
    output logic [15:0]                             stat_partial
`endif
);

    localparam int W  = NUM_BYTES * BYTE_W;
    localparam int CW = count_width(NUM_BYTES);

    pack_state_t   state;
    pack_state_t   state_nxt;
    logic [W-1:0]  acc_data;
    logic [CW-1:0] acc_count;

    logic [W-1:0]  fill_data;
    logic [CW-1:0] fill_count;
    logic [W-1:0]  load_data;
    logic [CW-1:0] load_count;
    logic          load_parity;
    logic          in_xfer;
    logic          out_xfer;
    logic          out_free;
    logic          complete;
    logic          load;
    logic          acc_write;
    logic          acc_clear;

    assign in_ready = (state == FILL);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        fill_data = acc_data;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (acc_count == CW'(k)) begin
                fill_data[k*BYTE_W +: BYTE_W] = in_data;
            end
        end
        fill_count = acc_count + CW'(1);
        complete   = in_xfer && ((fill_count == CW'(NUM_BYTES)) || in_last);

        state_nxt  = state;
        load       = 1'b0;
        acc_write  = 1'b0;
        acc_clear  = 1'b0;
        load_data  = fill_data;
        load_count = fill_count;

        case (state)
            FILL: begin
                if (complete && out_free) begin
                    load      = 1'b1;
                    acc_clear = 1'b1;
                end else if (in_xfer) begin
                    acc_write = 1'b1;
                    if (complete) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                // The accumulator already holds the finished word.
                load_data  = acc_data;
                load_count = acc_count;
                if (out_free) begin
                    load      = 1'b1;
                    acc_clear = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    word_parity #(
        .NUM_BYTES (NUM_BYTES),
        .ODD_PARITY(ODD_PARITY)
    ) u_word_parity (
        .word  (load_data),
        .parity(load_parity)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_data  <= '0;
            acc_count <= '0;
        end else if (acc_clear) begin
            acc_data  <= '0;
            acc_count <= '0;
        end else if (acc_write) begin
            acc_data  <= fill_data;
            acc_count <= fill_count;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
            out_parity <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= load_data;
            out_count  <= load_count;
            out_parity <= load_parity;
        end else if (out_xfer) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef PARITY_PACKER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_words   <= '0;
            stat_partial <= '0;
        end else if (out_xfer) begin
            if (stat_words != 16'hFFFF) begin
                stat_words <= stat_words + 16'd1;
            end
            if ((out_count < CW'(NUM_BYTES)) && (stat_partial != 16'hFFFF)) begin
                stat_partial <= stat_partial + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_parity_packer.sv
// Self-checking bench for parity_packer: vector table, corner-case sequences and
// randomized streaming against a queue-based packing model.
module tb_parity_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_parity, out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        o_in_ready, o_out_parity, o_out_valid;
    logic [31:0] o_out_data;
    logic [2:0]  o_out_count;
`ifdef PARITY_PACKER_STATS_EN
    logic [15:0] stat_words, stat_partial, o_stat_words, o_stat_partial;
`endif

    always #5 clock = ~clock;

    parity_packer #(.NUM_BYTES(4), .ODD_PARITY(1'b0)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_count(out_count), .out_parity(out_parity), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef PARITY_PACKER_STATS_EN
        , .stat_words(stat_words), .stat_partial(stat_partial)
`endif
    );

    parity_packer #(.NUM_BYTES(4), .ODD_PARITY(1'b1)) dut_odd (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(o_in_ready), .out_data(o_out_data),
        .out_count(o_out_count), .out_parity(o_out_parity), .out_valid(o_out_valid),
        .out_ready(out_ready)
`ifdef PARITY_PACKER_STATS_EN
        , .stat_words(o_stat_words), .stat_partial(o_stat_partial)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          count;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] cur_data = 32'h0;
    int          cur_n = 0;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic        last;
        logic [31:0] exp_data;
        logic [2:0]  exp_cnt;
        logic        exp_par;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference packing: bytes fill lanes in arrival order; a word closes at 4 bytes or on last.
    task automatic model_accept(input logic [7:0] b, input logic last);
        word_t w;
        cur_data = cur_data | ({24'h0, b} << (8 * cur_n));
        cur_n++;
        if (cur_n == 4 || last) begin
            w.data  = cur_data;
            w.count = cur_n;
            exp_q.push_back(w);
            cur_data = 32'h0;
            cur_n    = 0;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        cur_data = 32'h0;
        cur_n    = 0;
    endtask

    task automatic check_out();
        word_t w;
        if (exp_q.size() == 0) begin
            chk("unexpected_word", out_data, 32'hxxxxxxxx);
        end else begin
            w = exp_q.pop_front();
            chk("model_data", out_data, w.data);
            chk("model_count", {29'h0, out_count}, w.count);
            chk("model_parity", {31'h0, out_parity}, {31'h0, ^w.data});
            chk("model_odd_parity", {31'h0, o_out_parity}, {31'h0, ~(^w.data)});
        end
    endtask

    // Outputs are registered, so they are stable here; transfers are judged before the edge.
    task automatic tick();
        if (out_valid && out_ready) check_out();
        if (in_valid && in_ready) model_accept(in_data, in_last);
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    vec_t vecs[6];
    int   idle;

    initial begin
        vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 3'd4, 1'b0};
        vecs[1] = '{1, 32'h00000001, 1'b1, 32'h00000001, 3'd1, 1'b1};
        vecs[2] = '{2, 32'h0000FF80, 1'b1, 32'h0000FF80, 3'd2, 1'b1};
        vecs[3] = '{3, 32'h00030201, 1'b1, 32'h00030201, 3'd3, 1'b0};
        vecs[4] = '{4, 32'hDDCCBBAA, 1'b0, 32'hDDCCBBAA, 3'd4, 1'b0};
        vecs[5] = '{4, 32'h010000FF, 1'b1, 32'h010000FF, 3'd4, 1'b1};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_count", {29'h0, out_count}, 32'd0);
        chk("rst_out_parity", {31'h0, out_parity}, 32'd0);
        reset = 1'b0;
        tick();

        // Table: each packet sent back to back, then checked one cycle after its last accept.
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < vecs[v].n; b++) begin
                chk("tbl_in_ready", {31'h0, in_ready}, 32'd1);
                send(vecs[v].bytes[8*b +: 8], (b == vecs[v].n - 1) && vecs[v].last);
            end
            chk("tbl_out_valid", {31'h0, out_valid}, 32'd1);
            chk("tbl_out_data", out_data, vecs[v].exp_data);
            chk("tbl_out_count", {29'h0, out_count}, {29'h0, vecs[v].exp_cnt});
            chk("tbl_out_parity", {31'h0, out_parity}, {31'h0, vecs[v].exp_par});
            chk("tbl_odd_parity", {31'h0, o_out_parity}, {31'h0, ~vecs[v].exp_par});
            tick();
            chk("tbl_drained", {31'h0, out_valid}, 32'd0);
        end

        // Backpressure: two words, second parks in HOLD.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("bp_in_ready_fill", {31'h0, in_ready}, 32'd1);
            send(8'(i), 1'b0);
        end
        chk("bp_in_ready_hold", {31'h0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_stable_data", out_data, 32'h04030201);
            chk("bp_stable_count", {29'h0, out_count}, 32'd4);
            chk("bp_hold_in_ready", {31'h0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_second_valid", {31'h0, out_valid}, 32'd1);
        chk("bp_second_data", out_data, 32'h08070605);
        chk("bp_in_ready_back", {31'h0, in_ready}, 32'd1);
        tick();
        chk("bp_empty", {31'h0, out_valid}, 32'd0);
        chk("bp_queue_empty", exp_q.size(), 32'd0);

        // Streaming: random bytes and packet ends, consumer always ready.
        idle = 0;
        for (int i = 0; i < 64; i++) begin
            if (!in_ready) idle++;
            send(8'($urandom), (i == 63) || ($urandom_range(0, 3) == 0));
        end
        tick();
        tick();
        chk("stream_idle_cycles", idle, 32'd0);
        chk("stream_queue_empty", exp_q.size(), 32'd0);
        chk("stream_partial_empty", cur_n, 32'd0);

        // Reset with a pending output word and a half-filled accumulator.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'(8'h50 + i), 1'b0);
        chk("pre_rst_valid", {31'h0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("mid_rst_out_data", out_data, 32'h0);
        chk("mid_rst_out_count", {29'h0, out_count}, 32'd0);
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        chk("post_rst_valid", {31'h0, out_valid}, 32'd1);
        chk("post_rst_data", out_data, 32'hDDCCBBAA);
        chk("post_rst_count", {29'h0, out_count}, 32'd4);
        tick();
        chk("post_rst_queue_empty", exp_q.size(), 32'd0);

`ifdef PARITY_PACKER_STATS_EN
        reset = 1'b1;
        #1;
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("stat_rst_words", {16'h0, stat_words}, 32'd0);
        for (int w = 0; w < 3; w++) for (int b = 0; b < 4; b++) send(8'(w * 4 + b), 1'b0);
        send(8'h7E, 1'b1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        tick();
        tick();
        chk("stat_words", {16'h0, stat_words}, 32'd5);
        chk("stat_partial", {16'h0, stat_partial}, 32'd2);
        force dut.stat_words = 16'hFFFF;
        force dut.stat_partial = 16'hFFFF;
        #1;
        release dut.stat_words;
        release dut.stat_partial;
        send(8'h33, 1'b1);
        tick();
        tick();
        chk("stat_words_sat", {16'h0, stat_words}, 32'h0000FFFF);
        chk("stat_partial_sat", {16'h0, stat_partial}, 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_packer.md
# parity_packer

Upstream feeder for the 32-bit word parity stage. Accepts a byte stream over a valid/ready handshake and packs up to NUM_BYTES bytes, little-endian, into one word. Emits the word with its parity bit and a byte count over a second valid/ready handshake. Short packets are flushed with `in_last` and zero-padded.

## Interface
- NUM_BYTES, 4: bytes per output word; word width is NUM_BYTES*8.
- ODD_PARITY, 0: 0 selects even parity (`out_parity` = XOR of all word bits); 1 selects odd parity (inverted).
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_data  input  8  input byte.
- in_valid  input  1  byte offered.
- in_last  input  1  offered byte closes the current word; qualified by `in_valid`.
- in_ready  output  1  packer accepts a byte this cycle.
- out_data  output  NUM_BYTES*8  packed word; byte k in bits [8k+7:8k].
- out_count  output  $clog2(NUM_BYTES+1)  number of valid bytes, 1..NUM_BYTES.
- out_parity  output  1  parity of `out_data`.
- out_valid  output  1  word held in the output register.
- out_ready  input  1  consumer takes the word this cycle.
- stat_words  output  16  words emitted; present only with PARITY_PACKER_STATS_EN.
- stat_partial  output  16  words emitted with `out_count` < NUM_BYTES; present only with PARITY_PACKER_STATS_EN.

## Operation
- **Storage:** an accumulator (byte count plus data) and one output register. The FSM has two states, FILL and HOLD.
- **Transfers:**
  - Input transfer: `in_valid && in_ready`.
  - Output transfer: `out_valid && out_ready`.
  - `out_free` = `!out_valid || out_ready`.
- **FILL state:**
  - `in_ready` = 1.
  - An accepted byte is written to lane `count`, and `count` increments.
  - The byte completes the word if `count` reaches NUM_BYTES or `in_last` = 1.
  - On completion with `out_free`: the word, count and parity load into the output register. The accumulator clears (data 0, count 0). State stays FILL.
  - On completion without `out_free`: the completed word stays in the accumulator and the state moves to HOLD.
- **HOLD state:**
  - `in_ready` = 0.
  - When `out_free`, the accumulator loads into the output register and clears, and the state returns to FILL.
- **Drain:** an output transfer with no load this cycle clears `out_valid`.
- **Padding and parity:** unused lanes are 0, so padding never affects parity. `out_parity` = ^`out_data` ^ ODD_PARITY. It is computed from the completed word and registered with it.
- **Boundary cases:**
  - `in_last` on the NUM_BYTES-th byte gives an ordinary full word, `out_count` = NUM_BYTES.
  - `in_last` on the first byte gives `out_count` = 1.
  - `in_last` without `in_valid` is ignored. There are no empty words.
- **Data stability:** `out_data`, `out_count` and `out_parity` are stable while `out_valid && !out_ready`.
- **Reset at any point:** discards the partial word and any pending output. Outputs return to reset values with no residual word after release.

## Timing
- **Reset values:** `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_count` = 0, `out_parity` = 0, state FILL, accumulator cleared, stat counters 0.
- **Latency:** the word-completing byte accepted at edge N gives `out_valid` = 1 after edge N (visible in cycle N+1) when `out_free`.
- **Throughput:** sustained 1 byte/cycle with `out_ready` held at 1. No bubbles, including back-to-back single-byte words.
- **Backpressure:** in HOLD, `in_ready` falls in the cycle after the completing byte. It rises in the cycle after the HOLD word moves to the output register.
- **No combinational paths:** `in_ready` depends only on registered state. Nothing combinational runs from `out_ready` or `in_last` to any output.

## Configuration
- PARITY_PACKER_STATS_EN defined:
  - `stat_words` increments on every output transfer.
  - `stat_partial` increments on output transfers with `out_count` < NUM_BYTES.
  - Both saturate at 0xFFFF and clear only on reset.
- PARITY_PACKER_STATS_EN undefined: both ports and their counters are absent. Datapath behaviour is identical.

## Structure
- Shared package `parity_pkg`:
  - BYTE_W = 8.
  - typedef `pack_state_t` {FILL, HOLD}.
  - Function for count width from NUM_BYTES.
- One sub-module, `word_parity`: combinational XOR reduction of a NUM_BYTES*8 word with the ODD_PARITY option. It is instantiated once on the completed-word path.

## Test plan
- **Full word:** bytes 0x11, 0x22, 0x33, 0x44, `out_ready` = 1 → one word: `out_data` = 0x44332211, `out_count` = 4, `out_parity` = 0, `out_valid` in the cycle after the 4th accept.
- **Partial flush:** byte 0x01 with `in_last` = 1 → `out_data` = 0x00000001, `out_count` = 1, `out_parity` = 1. Repeat with ODD_PARITY = 1 → `out_parity` = 0.
- **Backpressure:** `out_ready` = 0, 8 bytes 0x01..0x08 offered → first word 0x04030201 held stable, `in_ready` = 0 after the 8th byte, second word 0x08070605 in HOLD. Raise `out_ready` → both words delivered in order, then `in_ready` = 1.
- **Streaming:** 64 random bytes with random `in_last` and `out_ready` held at 1 → zero idle cycles on `in_ready`. Every word matches the reference packing, and parity matches ^data.
- **Reset:** assert `reset` after 2 bytes of a word and with a word pending in the output → `out_valid` = 0 immediately. Next bytes 0xAA, 0xBB, 0xCC, 0xDD → 0xDDCCBBAA with no residue.
- **Stats (PARITY_PACKER_STATS_EN):** 3 full words + 2 `in_last` partials → `stat_words` = 5, `stat_partial` = 2. Force 0xFFFF → counters hold at 0xFFFF.
